dtcm_arbiter: RTL
=================

# dtcm_arbiter

Shares the single-port DTCM between the CPU load/store path and a DMA/loader burst port. Sits between the memory-access stage and the DTCM macro. The CPU has fixed priority. The DMA port is served in idle data slots, with a starvation limit that stalls the CPU for one cycle to guarantee DMA forward progress. Internally the block sequences DMA bursts of up to 16 words: address generation, beat counting, read-return tagging, and completion.

## Interface
- `STARVE_MAX`, default 8: consecutive blocked DMA cycles before a forced DMA slot (range 1..255).
- `LEN_W`, default 4: width of the burst length field; max burst is 2^LEN_W words.

- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_en`  in  1  CPU access request this cycle; held stable while `cpu_stall`=1.
- `cpu_wen`  in  4  CPU byte write enables; 0 means read.
- `cpu_addr`  in  32  CPU byte address.
- `cpu_wdata`  in  32  CPU write data.
- `cpu_rdata`  out  32  DTCM read data for the CPU, one cycle after its access.
- `cpu_stall`  out  1  CPU access not performed this cycle; CPU must hold and retry.
- `dma_req_valid`  in  1  burst request valid.
- `dma_req_ready`  out  1  burst request accepted when high together with `dma_req_valid`.
- `dma_req_write`  in  1  1 = write burst, 0 = read burst.
- `dma_req_addr`  in  32  burst base address; bits [1:0] are ignored and treated as 0.
- `dma_req_len`  in  LEN_W  beats minus 1.
- `dma_wdata`  in  32  current write beat data.
- `dma_wbeat`  out  1  current write beat consumed this cycle.
- `dma_rdata`  out  32  read beat data.
- `dma_rvalid`  out  1  `dma_rdata` valid.
- `dma_done`  out  1  one-cycle pulse at burst completion.
- `dtcm_en`  out  1  DTCM access enable.
- `dtcm_wen`  out  4  DTCM byte write enables.
- `dtcm_addr`  out  32  DTCM address.
- `dtcm_wdata`  out  32  DTCM write data.
- `dtcm_rdata`  in  32  DTCM read data, synchronous, one cycle after the address.

## Operation
- FSM states and transitions:
  - IDLE: `dma_req_ready`=1. A request handshake latches write flag, word-aligned base address and length, clears the beat counter, and moves to BURST.
  - BURST: one beat is issued per DMA-granted cycle. When the beat with index `len` is issued, move to DRAIN.
  - DRAIN: one cycle. `dma_done`=1, then return to IDLE.
- DMA grant in BURST, per cycle:
  - `cpu_en`=0: DMA gets the slot.
  - `cpu_en`=1 and starve count < `STARVE_MAX`: CPU gets the slot and the starve count increments.
  - `cpu_en`=1 and starve count = `STARVE_MAX`: DMA gets the slot, `cpu_stall`=1, and the starve count clears.
  - The starve count also clears on every DMA grant and on leaving BURST.
- Beat address is base + 4×beat. Arithmetic is 32-bit and wraps modulo 2^32: base 0xFFFF_FFFC with len 1 addresses 0xFFFF_FFFC, then 0x0000_0000.
- DTCM mux:
  - DMA slot: `dtcm_en`=1; `dtcm_wen`=4'hF for a write, 0 for a read.
  - Otherwise the CPU signals pass through, with `dtcm_en`=`cpu_en`.
- Write beats: `dma_wbeat`=1 in the granted cycle. `dma_wdata` is sampled by the DTCM in that same cycle, and the source advances to the next word on `dma_wbeat`.
- Read return: a one-bit owner flag is registered at each access. `dma_rvalid` is high the cycle after a DMA read beat, with `dma_rdata`=`dtcm_rdata`. `cpu_rdata`=`dtcm_rdata` always; the CPU ignores it when it was not the owner.
- `cpu_stall` is only ever asserted in BURST; it is 0 in IDLE and DRAIN.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE, counters=0, owner=CPU.
  - Output values during reset: `dma_req_ready`=1 (decoded from IDLE), `cpu_stall`=0, `dma_wbeat`=0, `dma_rvalid`=0, `dma_done`=0.
  - `dtcm_en` and `dtcm_wen` follow the CPU inputs during reset.
- Reset mid-burst aborts immediately. No `dma_done` is produced and no further DMA beats are issued.
- With an idle CPU, burst latency is:
  - handshake at cycle 0;
  - beats at cycles 1..len+1;
  - last read data at cycle len+2, coinciding with DRAIN and `dma_done`.
- A continuously busy CPU still yields one DMA beat every `STARVE_MAX`+1 cycles.
- `cpu_stall`, `dma_wbeat` and the `dtcm_*` outputs are combinational from state and inputs. All other outputs are registered.
- A new request cannot be accepted in DRAIN. The earliest back-to-back handshake is the cycle after DRAIN.

## Structure
- Package `dtcm_arb_pkg` holds:
  - the state enum (`ARB_IDLE`, `ARB_BURST`, `ARB_DRAIN`);
  - the `STARVE_MAX` default;
  - a `dma_req_t` struct {write, addr, len}.
- One sub-module, `dma_addr_gen`: latches base/len, produces the beat address and the last-beat flag, and advances on grant.
- Arbitration, starvation counter, owner flag and FSM stay in the top module.

## Test plan
- Idle CPU, read burst base 0x100, len 3: DTCM addresses 0x100/0x104/0x108/0x10C on cycles 1–4; `dma_rvalid` on cycles 2–5; `dma_done` on cycle 5.
- `cpu_en`=1 every cycle, write burst len 1, `STARVE_MAX`=8: `cpu_stall` pulses exactly on cycles 9 and 18; `dma_wbeat` in the same cycles; `dma_done` on cycle 19.
- Alternating `cpu_en`: the DMA takes only the CPU-idle cycles; `cpu_stall` is never asserted; CPU read data returns with the owner flag set to CPU.
- Base 0xFFFF_FFFC, len 1: second beat address is 0x0000_0000.
- `reset_n` low during beat 2 of len 7: all outputs return immediately to their reset values; `dma_done` never pulses; the next request is accepted on the first cycle after release.
- `dma_req_valid` held through DRAIN: the handshake occurs only on the following IDLE cycle.

Source files
------------

// File: rtl/dtcm_arbiter_pkg.sv
// Shared types and constants for the DTCM arbiter: FSM states, read-data
// owner flag and the DMA burst request record.
package dtcm_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BURST,
    ARB_DRAIN
  } arb_state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_DMA
  } owner_e;

  localparam int STARVE_MAX_DEF = 8;
  // Widest burst length field supported; narrower LEN_W is zero-extended into it.
  localparam int REQ_LEN_MAX_W  = 8;

  typedef struct packed {
    logic                     write;
    logic [31:0]              addr;
    logic [REQ_LEN_MAX_W-1:0] len;
  } dma_req_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/dtcm_arbiter_if.sv
// Bus bundle between the arbiter and its neighbours: CPU load/store port,
// DMA burst port and the DTCM macro port.
interface dtcm_arb_if #(parameter int LEN_W = 4);
  logic             cpu_en;
  logic [3:0]       cpu_wen;
  logic [31:0]      cpu_addr;
  logic [31:0]      cpu_wdata;
  logic [31:0]      cpu_rdata;
  logic             cpu_stall;
  logic             dma_req_valid;
  logic             dma_req_ready;
  logic             dma_req_write;
  logic [31:0]      dma_req_addr;
  logic [LEN_W-1:0] dma_req_len;
  logic [31:0]      dma_wdata;
  logic             dma_wbeat;
  logic [31:0]      dma_rdata;
  logic             dma_rvalid;
  logic             dma_done;
  logic             dtcm_en;
  logic [3:0]       dtcm_wen;
  logic [31:0]      dtcm_addr;
  logic [31:0]      dtcm_wdata;
  logic [31:0]      dtcm_rdata;

  modport slave (
    input  cpu_en, cpu_wen, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_req_valid, dma_req_write, dma_req_addr, dma_req_len, dma_wdata,
    output dma_req_ready, dma_wbeat, dma_rdata, dma_rvalid, dma_done,
    output dtcm_en, dtcm_wen, dtcm_addr, dtcm_wdata,
    input  dtcm_rdata
  );

  modport master (
    output cpu_en, cpu_wen, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_req_valid, dma_req_write, dma_req_addr, dma_req_len, dma_wdata,
    input  dma_req_ready, dma_wbeat, dma_rdata, dma_rvalid, dma_done,
    input  dtcm_en, dtcm_wen, dtcm_addr, dtcm_wdata,
    output dtcm_rdata
  );
endinterface

// File: rtl/dtcm_arbiter_addr_gen.sv
// DMA burst address generator: latches base and length on the request
// handshake, then steps one word per granted beat.
module dma_addr_gen
  import dtcm_arb_pkg::*;
#(
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic [31:0]              base,
  input  logic [REQ_LEN_MAX_W-1:0] len,
  input  logic                     adv,
  output logic [31:0]              beat_addr,
  output logic                     last_beat
);

  logic [LEN_W-1:0]         beat_q, beat_d;
  logic [31:0]              base_q, base_d;
  logic [REQ_LEN_MAX_W-1:0] len_q, len_d;

  always_comb begin
    beat_d = beat_q;
    base_d = base_q;
    len_d  = len_q;
    if (load) begin
      beat_d = '0;
      base_d = word_align(base);
      len_d  = len;
    end else if (adv) begin
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) beat_q <= '0;
    else          beat_q <= beat_d;
  end

  always_ff @(posedge clk) begin
    base_q <= base_d;
    len_q  <= len_d;
  end

  // 32-bit add wraps naturally past 0xFFFF_FFFC.
  assign beat_addr = base_q + 32'({beat_q, 2'b00});
  assign last_beat = (REQ_LEN_MAX_W'(beat_q) == len_q);

endmodule

// File: rtl/dtcm_arbiter.sv
// Single-port DTCM arbiter: CPU has fixed priority, DMA bursts fill idle
// slots, and a starvation counter forces a DMA slot after STARVE_MAX losses.
module dtcm_arbiter
  import dtcm_arb_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int LEN_W      = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  dtcm_arb_if.slave  bus
);

  arb_state_e state_q, state_d;
  logic [7:0] starve_q, starve_d;
  owner_e     owner_q, owner_d;
  logic       wr_q, wr_d;

  dma_req_t    req;
  logic        in_burst, starved, dma_grant, hs, last_beat;
  logic [31:0] beat_addr;

  always_comb begin
    req.write = bus.dma_req_write;
    req.addr  = bus.dma_req_addr;
    req.len   = REQ_LEN_MAX_W'(bus.dma_req_len);
  end

  assign in_burst  = (state_q == ARB_BURST);
  assign starved   = (starve_q == 8'(STARVE_MAX));
  assign dma_grant = in_burst && (!bus.cpu_en || starved);
  assign hs        = (state_q == ARB_IDLE) && bus.dma_req_valid;

  dma_addr_gen #(.LEN_W(LEN_W)) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (hs),
    .base      (req.addr),
    .len       (req.len),
    .adv       (dma_grant),
    .beat_addr (beat_addr),
    .last_beat (last_beat)
  );

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    case (state_q)
      ARB_IDLE: begin
        if (hs) begin
          state_d = ARB_BURST;
          wr_d    = req.write;
        end
      end
      ARB_BURST: if (dma_grant && last_beat) state_d = ARB_DRAIN;
      ARB_DRAIN: state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase

    starve_d = (!in_burst || dma_grant) ? 8'd0 : starve_q + 8'd1;
    // Only DMA read beats hand the returning data to the DMA side.
    owner_d  = (dma_grant && !wr_q) ? OWN_DMA : OWN_CPU;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ARB_IDLE;
      starve_q <= 8'd0;
      owner_q  <= OWN_CPU;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
    end
  end

  always_comb begin
    bus.dma_req_ready = (state_q == ARB_IDLE);
    bus.dma_done      = (state_q == ARB_DRAIN);
    bus.dma_rvalid    = (owner_q == OWN_DMA);
    bus.dma_rdata     = bus.dtcm_rdata;
    bus.cpu_rdata     = bus.dtcm_rdata;
    bus.cpu_stall     = in_burst && bus.cpu_en && starved;
    bus.dma_wbeat     = dma_grant && wr_q;

    bus.dtcm_en    = bus.cpu_en;
    bus.dtcm_wen   = bus.cpu_wen;
    bus.dtcm_addr  = bus.cpu_addr;
    bus.dtcm_wdata = bus.cpu_wdata;
    if (dma_grant) begin
      bus.dtcm_en    = 1'b1;
      bus.dtcm_wen   = wr_q ? 4'hF : 4'h0;
      bus.dtcm_addr  = beat_addr;
      bus.dtcm_wdata = bus.dma_wdata;
    end
  end

endmodule
